// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES-128 encryption, one round per clock.
// Consumes the flattened round keys from key expansion and holds the
// ciphertext with a level done flag until the next accepted start.
module aes_cipher_core #(
   parameter int Rounds_P     = 10,
   parameter int Block_Bits_P = 128
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 key_valid,
   input  logic [(Rounds_P+1)*Block_Bits_P-1:0] exp_key,
   input  logic [Block_Bits_P-1:0]              plaintext,
   output logic [Block_Bits_P-1:0]              ciphertext,
   output logic                                 busy,
   output logic                                 done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   localparam logic [3:0] Last_Round_C = 4'(Rounds_P - 1);

   // GF(2^8) doubling with reduction polynomial 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

   // S-box: multiplicative inverse as b^254 (b^2 * b^4 * ... * b^128), then affine map.
   function automatic logic [7:0] s_box(input logic [7:0] b);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = b;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {s_box(w[31:24]), s_box(w[23:16]), s_box(w[15:8]), s_box(w[7:0])};
   endfunction

   function automatic logic [Block_Bits_P-1:0] sub_bytes(input logic [Block_Bits_P-1:0] s);
      logic [Block_Bits_P-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = sub_word(s[127-32*c -: 32]);
      return o;
   endfunction

   // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
   function automatic logic [Block_Bits_P-1:0] shift_rows(input logic [Block_Bits_P-1:0] s);
      logic [Block_Bits_P-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [Block_Bits_P-1:0] mix_columns(input logic [Block_Bits_P-1:0] s);
      logic [Block_Bits_P-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
      return o;
   endfunction

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [3:0]              r_round;
   logic [Block_Bits_P-1:0] r_data;
   logic [Block_Bits_P-1:0] r_ciphertext;
   logic                    r_busy;
   logic                    r_done;

   logic                    w_accept;
   logic                    w_do_round;
   logic                    w_do_final;
   logic                    w_bad_state;
   logic [Block_Bits_P-1:0] w_rk;
   logic [Block_Bits_P-1:0] w_shifted;
   logic [Block_Bits_P-1:0] w_round_out;
   logic [Block_Bits_P-1:0] w_final_out;
   logic [Block_Bits_P-1:0] w_initial;

   assign w_rk        = exp_key[Block_Bits_P*r_round +: Block_Bits_P];
   assign w_shifted   = shift_rows(sub_bytes(r_data));
   assign w_round_out = mix_columns(w_shifted) ^ w_rk;
   assign w_final_out = w_shifted ^ w_rk;
   assign w_initial   = plaintext ^ exp_key[Block_Bits_P-1:0];

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode and per-state datapath strobes.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_do_round  = 1'b0;
      w_do_final  = 1'b0;
      w_bad_state = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && key_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            w_do_round = 1'b1;
            if (r_round == Last_Round_C) w_state_nxt = S_FINAL;
         end
         S_FINAL: begin
            w_do_final  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_bad_state = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath registers: load, iterate rounds, capture the final result.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_round      <= '0;
         r_data       <= '0;
         r_ciphertext <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, as the flops do.
         if (w_accept) begin
            r_data  <= w_initial;
            r_round <= 4'd1;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
         end else if (w_do_round) begin
            r_data  <= w_round_out;
            r_round <= r_round + 4'd1;
         end else if (w_do_final) begin
            r_ciphertext <= w_final_out;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_round      <= '0;
         end else if (w_bad_state) begin
            r_busy  <= 1'b0;
            r_round <= '0;
         end
      end
   end

   assign ciphertext = r_ciphertext;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_aes_cipher_core.sv
// tb_aes_cipher_core: directed FIPS-197 vectors against a transaction-level
// AES model (table S-box, 4x4 byte state) checked on every falling edge.
module tb_aes_cipher_core;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] RK10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            key_valid = 1'b0;
   logic [1407:0]   exp_key = '0;
   logic [127:0]    plaintext = '0;
   logic [127:0]    ciphertext;
   logic            busy;
   logic            done;

   int              n_vec  = 0;
   int              n_fail = 0;
   logic            chk_en = 1'b0;
   logic [127:0]    cur_key = '0;
   logic [7:0]      sbox_t [256];

   // Model state: cycles left in flight, pending result, visible outputs.
   int              m_left = 0;
   logic [127:0]    m_pend = '0;
   logic [127:0]    m_ct = '0;
   logic            m_busy = 1'b0;
   logic            m_done = 1'b0;

   aes_cipher_core dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .key_valid  (key_valid),
      .exp_key    (exp_key),
      .plaintext  (plaintext),
      .ciphertext (ciphertext),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   // Inverse found by search, affine transform in its bitwise FIPS form.
   task automatic build_sbox();
      logic [7:0] c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox_t[x] = s;
      end
   endtask

   function automatic logic [1407:0] expand_key(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rcon = 8'h01;
      logic [1407:0] ek = '0;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) ek[128*(i/4) + 32*(3 - i%4) +: 32] = w[i];
      return ek;
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
      logic [1407:0] ek;
      logic [7:0]    s [4][4];
      logic [7:0]    t [4][4];
      logic [127:0]  o = '0;
      ek = expand_key(key);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ ek[127-8*(4*c+r) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sbox_t[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
               s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
            for (int r = 0; r < 4; r++)
               s[r][c] = s[r][c] ^ ek[128*rnd + 127 - 8*(4*c+r) -: 8];
         end
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(4*c+r) -: 8] = s[r][c];
      return o;
   endfunction

   // Transaction model: accept when idle, result appears 10 edges later.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_left = 0;
         m_ct   = '0;
         m_busy = 1'b0;
         m_done = 1'b0;
      end else if (m_left == 0) begin
         if (start && key_valid) begin
            m_pend = aes_model(cur_key, plaintext);
            m_left = 10;
            m_busy = 1'b1;
            m_done = 1'b0;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_ct   = m_pend;
            m_done = 1'b1;
            m_busy = 1'b0;
         end
      end
   end

   // Cycle compare of all outputs against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         check("cyc_busy", {127'b0, busy}, {127'b0, m_busy});
         check("cyc_done", {127'b0, done}, {127'b0, m_done});
         check("cyc_ct", ciphertext, m_ct);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_key(input logic [127:0] key);
      cur_key = key;
      exp_key = expand_key(key);
   endtask

   task automatic accept(input logic [127:0] pt);
      plaintext = pt;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      check("acc_busy", {127'b0, busy}, 128'd1);
      check("acc_done", {127'b0, done}, 128'd0);
   endtask

   // Counts edges after the accept edge until done rises (bounded).
   task automatic wait_done(output int edges, output int busy_n);
      edges  = 0;
      busy_n = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && edges < 40) begin
         tick();
         edges++;
         if (busy === 1'b1 && done !== 1'b1) busy_n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int edges, busy_n, low;
      build_sbox();
      check("pin_rk10", expand_key(KEY_B)[1407:1280], RK10B);
      check("pin_model_b", aes_model(KEY_B, PT_B), CT_B);
      check("pin_model_c1", aes_model(KEY_C, PT_C), CT_C);

      repeat (2) tick();
      reset  = 1'b0;
      chk_en = 1'b1;
      check("rst_busy", {127'b0, busy}, 128'd0);
      check("rst_done", {127'b0, done}, 128'd0);
      check("rst_ct", ciphertext, 128'd0);

      // start held with key_valid low: nothing accepted
      set_key(KEY_B);
      plaintext = PT_B;
      start     = 1'b1;
      repeat (20) tick();
      check("nokv_busy", {127'b0, busy}, 128'd0);
      check("nokv_done", {127'b0, done}, 128'd0);
      check("nokv_ct", ciphertext, 128'd0);
      key_valid = 1'b1;
      tick();
      start = 1'b0;
      check("kv_accept_busy", {127'b0, busy}, 128'd1);
      wait_done(edges, busy_n);
      check("kv_latency", 128'(edges), 128'd10);
      check("kv_ct", ciphertext, CT_B);

      // single-cycle start, App. B
      accept(PT_B);
      wait_done(edges, busy_n);
      check("b_latency", 128'(edges), 128'd10);
      check("b_busy_cycles", 128'(busy_n), 128'd10);
      check("b_busy_at_done", {127'b0, busy}, 128'd0);
      check("b_ct", ciphertext, CT_B);

      // start pulses at edges 3 and 7 while busy are ignored
      accept(PT_B);
      edges = 0;
      while (done !== 1'b1 && edges < 40) begin
         start = (edges == 2 || edges == 6);
         tick();
         edges++;
      end
      start = 1'b0;
      check("ign_latency", 128'(edges), 128'd10);
      check("ign_ct", ciphertext, CT_B);

      // App. C.1 then back-to-back zero block at the earliest edge
      set_key(KEY_C);
      accept(PT_C);
      wait_done(edges, busy_n);
      check("c1_latency", 128'(edges), 128'd10);
      check("c1_ct", ciphertext, CT_C);
      plaintext = '0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_accept_done", {127'b0, done}, 128'd0);
      check("b2b_ct_held", ciphertext, CT_C);
      low = (done === 1'b0) ? 1 : 0;
      edges = 0;
      while (done !== 1'b1 && edges < 40) begin
         tick();
         edges++;
         if (done === 1'b0) low++;
      end
      check("b2b_done_low", 128'(low), 128'd10);
      check("b2b_ct", ciphertext, aes_model(KEY_C, 128'd0));

      // asynchronous reset at round 5
      accept(PT_C);
      repeat (4) tick();
      #2 reset = 1'b1;
      #1;
      check("arst_busy", {127'b0, busy}, 128'd0);
      check("arst_done", {127'b0, done}, 128'd0);
      check("arst_ct", ciphertext, 128'd0);
      repeat (2) tick();
      #2 reset = 1'b0;
      tick();
      accept(PT_C);
      wait_done(edges, busy_n);
      check("arst_latency", 128'(edges), 128'd10);
      check("arst_ct_after", ciphertext, CT_C);

      // idle hold with key_valid toggling and plaintext changing
      for (int i = 0; i < 50; i++) begin
         key_valid = i[0];
         plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
      end
      check("hold_done", {127'b0, done}, 128'd1);
      check("hold_ct", ciphertext, CT_C);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_cipher_core.md
Name: aes_cipher_core

Overview:
Iterative AES-128 encryption datapath that consumes the flattened round-key vector produced by the key expansion stage and its done flag. It computes one AES round per clock and holds the ciphertext with a level done flag until the next start. The block sits directly downstream of key expansion and upstream of the output/interface logic.

Parameters:
Rounds_P, 10, number of AES rounds; only 10 (AES-128) is supported.
Block_Bits_P, 128, data block width; fixed.

Ports:
clock  input  1  single system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to encrypt the block on plaintext; sampled on the rising clock edge.
key_valid  input  1  done flag from key expansion; exp_key is stable while high.
exp_key  input  1408  round keys; round key r = exp_key[128*r +: 128], r = 0..10; round key 0 equals the cipher key.
plaintext  input  128  input block; byte 0 = plaintext[127:120] (FIPS-197 column-major order).
ciphertext  output  128  result block, same byte order as plaintext; held until the next accepted start.
busy  output  1  high while a block is in flight.
done  output  1  level flag; high once ciphertext is valid, cleared by the next accepted start.

Behaviour:
- Reset (async, reset=1): state=IDLE, round counter=0, internal state register=0, ciphertext=0, busy=0, done=0. Asserting reset mid-operation aborts immediately; no partial result appears.
- Accept rule: start is accepted only when state=IDLE and key_valid=1. If start is high in any other case, it is ignored with no side effects. exp_key and plaintext are sampled on the accept edge (plaintext) and on each round edge (exp_key). exp_key must stay stable until done.
- FSM states: IDLE, ROUND, FINAL.
- IDLE, on accept edge: state_reg <= plaintext ^ rk0; round <= 1; done <= 0; busy <= 1; go to ROUND. Without accept: hold all registers.
- ROUND: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk[round]; round <= round+1. When round==9 on this edge, go to FINAL.
- FINAL: ciphertext <= ShiftRows(SubBytes(state_reg)) ^ rk10; done <= 1; busy <= 0; round <= 0; go to IDLE.
- Latency: if start is accepted at edge 0, then done=1 and ciphertext are valid after edge 10. The next start may be accepted at edge 11 at the earliest, giving a throughput of one block per 11 cycles.
- done remains high and ciphertext remains held through any number of idle cycles, and through key_valid dropping. A new accept clears done on that edge; ciphertext holds its old value until the new FINAL.
- Round counter: 4 bits, range 0..10; it never wraps. Unused states fall to IDLE with busy=0 and done unchanged.
- SubBytes uses the shared s_box_functions instance (sub_word applied per 32-bit column).
- ShiftRows: row r is rotated left by r bytes.
- MixColumns: GF(2^8) arithmetic with reduction polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- All datapath logic between the state register and its next value is combinational within one cycle. No other pipelining.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c expanded by the key expansion stage, plaintext 3243f6a8885a308d313198a2e0370734, start for one cycle -> done rises exactly 10 edges after accept; ciphertext = 3925841d02dc09fbdc118597196a0b32; busy high for edges 1..10.
2. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. Then issue back-to-back starts with a second plaintext 00000000000000000000000000000000 at the earliest legal edge -> both results are correct, and done drops for exactly one block period in between.
3. start held high continuously with key_valid=0 for 20 cycles -> no accept: busy=0, done=0, ciphertext=0. Raise key_valid -> accepted on the next edge.
4. start pulsed at edges 3 and 7 after an accept, while busy -> ignored; the result equals case 1 and is delivered at the original latency.
5. Assert reset asynchronously (between clock edges) at round 5 -> all outputs go to 0 immediately. After reset release, a new start produces the correct result at full latency.
6. After done, hold idle for 50 cycles while toggling key_valid and changing plaintext -> ciphertext and done=1 remain unchanged.
